// File: rtl/eq_slicer_pkg.sv
// -----------------------------------------------------------------------------
// eq_slicer_pkg
// Shared constants for the equaliser slicer / lock stage:
//   - lock FSM state encodings (IDLE/ACQ/TRACK)
//   - modulation select encodings (QPSK / 16-QAM)
//   - level_of(): constellation levels and slicing thresholds expressed in
//     input LSBs for a given number of fractional bits
// -----------------------------------------------------------------------------
package eq_slicer_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ACQ   = 2'd1;
   localparam state_t ST_TRACK = 2'd2;

   localparam logic MOD_QPSK  = 1'b0;
   localparam logic MOD_QAM16 = 1'b1;

   // Integer amplitude 'units' (e.g. -3, 1, 2) scaled to a fixed-point word
   // with 'nbf' fractional bits.
   function automatic int level_of(input int units, input int nbf);
      return units * (2 ** nbf);
   endfunction

endpackage

// File: rtl/eq_slicer_lock_if.sv
// -----------------------------------------------------------------------------
// eq_slicer_lock_if
// Symbol bus between the downsampler/equaliser and the slicer stage.
//   i_en_rate1          symbol strobe
//   i_data_I/i_data_Q   equalised I/Q samples (signed, NBT_IN bits)
//   i_mod_sel           0 = QPSK, 1 = 16-QAM
//   o_sym_I/o_sym_Q     decided symbols (same format as input)
//   o_err_I/o_err_Q     error towards the LMS tap update (NBT_ERR bits)
//   o_valid             one-cycle pulse marking new symbol/error
// Modports: master = symbol source / error consumer, slave = slicer.
// -----------------------------------------------------------------------------
interface eq_slicer_lock_if #(
   parameter int NBT_IN  = 12,
   parameter int NBT_ERR = 12
);
   logic                      i_en_rate1;
   logic signed [NBT_IN-1:0]  i_data_I;
   logic signed [NBT_IN-1:0]  i_data_Q;
   logic                      i_mod_sel;
   logic signed [NBT_IN-1:0]  o_sym_I;
   logic signed [NBT_IN-1:0]  o_sym_Q;
   logic signed [NBT_ERR-1:0] o_err_I;
   logic signed [NBT_ERR-1:0] o_err_Q;
   logic                      o_valid;

   modport master (
      output i_en_rate1, i_data_I, i_data_Q, i_mod_sel,
      input  o_sym_I, o_sym_Q, o_err_I, o_err_Q, o_valid
   );

   modport slave (
      input  i_en_rate1, i_data_I, i_data_Q, i_mod_sel,
      output o_sym_I, o_sym_Q, o_err_I, o_err_Q, o_valid
   );
endinterface

// File: rtl/eq_slicer_rail.sv
// -----------------------------------------------------------------------------
// eq_slicer_rail
// One-rail combinational slicer: decides the nearest QPSK / 16-QAM level,
// computes e = y - level, truncates to NBF_ERR fractional bits and saturates
// to NBT_ERR bits.
//   i_y        signed input sample (NBT_IN bits, NBF_IN fractional)
//   i_mod_sel  0 = QPSK (+/-1), 1 = 16-QAM (+/-1, +/-3)
//   o_level    decided level, same format as i_y
//   o_err_full saturated full-precision error (used for MSE)
//   o_err_lms  error handed to the LMS update
// Optional macro EQ_SIGN_ERR_EN: o_err_lms becomes a sign error
// (+1/-1/0 LSB); otherwise it equals o_err_full.
// -----------------------------------------------------------------------------
module eq_slicer_rail
   import eq_slicer_pkg::*;
#(
   parameter int NBT_IN  = 12,
   parameter int NBF_IN  = 9,
   parameter int NBT_ERR = 12,
   parameter int NBF_ERR = 9
) (
   input  logic signed [NBT_IN-1:0]  i_y,
   input  logic                      i_mod_sel,
   output logic signed [NBT_IN-1:0]  o_level,
   output logic signed [NBT_ERR-1:0] o_err_full,
   output logic signed [NBT_ERR-1:0] o_err_lms
);
   localparam int SHIFT   = NBF_IN - NBF_ERR;
   localparam int ERR_MAX = (2 ** (NBT_ERR - 1)) - 1;
   localparam int ERR_MIN = -(2 ** (NBT_ERR - 1));

   localparam logic signed [NBT_IN-1:0] LVL_P3 = NBT_IN'(level_of( 3, NBF_IN));
   localparam logic signed [NBT_IN-1:0] LVL_P1 = NBT_IN'(level_of( 1, NBF_IN));
   localparam logic signed [NBT_IN-1:0] LVL_M1 = NBT_IN'(level_of(-1, NBF_IN));
   localparam logic signed [NBT_IN-1:0] LVL_M3 = NBT_IN'(level_of(-3, NBF_IN));
   localparam logic signed [NBT_IN-1:0] THR_P2 = NBT_IN'(level_of( 2, NBF_IN));
   localparam logic signed [NBT_IN-1:0] THR_M2 = NBT_IN'(level_of(-2, NBF_IN));
   localparam logic signed [NBT_IN-1:0] THR_0  = '0;

   logic signed [NBT_IN:0] w_e;
   logic signed [NBT_IN:0] w_e_tr;
   logic signed [31:0]     w_e_wide;

   // Every comparison uses '>=', so a sample exactly on a threshold goes to
   // the upper level.
   always_comb begin
      // NOTE: assigning a default first guarantees every path drives o_level,
      // so no latch can be inferred.
      o_level = LVL_M1;
      if (i_mod_sel == MOD_QAM16) begin
         if      (i_y >= THR_P2) o_level = LVL_P3;
         else if (i_y >= THR_0)  o_level = LVL_P1;
         else if (i_y >= THR_M2) o_level = LVL_M1;
         else                    o_level = LVL_M3;
      end else begin
         o_level = (i_y >= THR_0) ? LVL_P1 : LVL_M1;
      end
   end

   // One extra bit holds the full difference; arithmetic shift floors.
   assign w_e      = (NBT_IN+1)'(i_y) - (NBT_IN+1)'(o_level);
   assign w_e_tr   = w_e >>> SHIFT;
   assign w_e_wide = 32'(w_e_tr);

   always_comb begin
      if (w_e_wide > ERR_MAX)      o_err_full = NBT_ERR'(ERR_MAX);
      else if (w_e_wide < ERR_MIN) o_err_full = NBT_ERR'(ERR_MIN);
      else                         o_err_full = NBT_ERR'(w_e_wide);
   end

`ifdef EQ_SIGN_ERR_EN
   always_comb begin
      o_err_lms = '0;
      if (w_e > 0)      o_err_lms = NBT_ERR'(1);
      else if (w_e < 0) o_err_lms = '1;
   end
`else
   assign o_err_lms = o_err_full;
`endif

endmodule

// File: rtl/eq_slicer_lock.sv
// -----------------------------------------------------------------------------
// eq_slicer_lock
// Decision / error / lock stage of the adaptive equaliser receive path.
// Slices equalised I/Q (via two eq_slicer_rail instances), registers symbol
// and error, estimates MSE over 2^LOG2_AVG symbols and runs the lock FSM
// that selects the LMS step size.
// Ports:
//   clk, i_reset   clock, synchronous active-high reset
//   i_en_rx        global enable; all state holds while low
//   io_bus         symbol bus (strobe, data, mod_sel in; sym, err, valid out)
//   o_mse          last window MSE, unsigned, 2*NBF_ERR fractional bits
//   o_mse_valid    one-cycle pulse per completed window
//   o_lock         high in TRACK
//   o_step_sel     0 = large step (IDLE/ACQ), 1 = small step (TRACK)
//   o_state        FSM state (IDLE=0, ACQ=1, TRACK=2)
// Optional macro EQ_SIGN_ERR_EN selects sign-error output on io_bus.o_err_*.
// -----------------------------------------------------------------------------
module eq_slicer_lock
   import eq_slicer_pkg::*;
#(
   parameter int NBT_IN     = 12,
   parameter int NBF_IN     = 9,
   parameter int NBT_ERR    = 12,
   parameter int NBF_ERR    = 9,
   parameter int LOG2_AVG   = 4,
   parameter int LOCK_THR   = 13107,
   parameter int UNLOCK_THR = 39322,
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 2
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_en_rx,
   eq_slicer_lock_if.slave      io_bus,
   output logic [2*NBT_ERR:0]   o_mse,
   output logic                 o_mse_valid,
   output logic                 o_lock,
   output logic                 o_step_sel,
   output logic [1:0]           o_state
);
   localparam int MSE_W  = 2*NBT_ERR + 1;
   localparam int ACC_W  = MSE_W + LOG2_AVG;
   localparam int HIT_W  = $clog2(LOCK_CNT + 1);
   localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

   logic                      w_strobe;
   logic                      w_mod_chg;
   logic                      w_win_last;
   logic signed [NBT_IN-1:0]  w_lvl_I, w_lvl_Q;
   logic signed [NBT_ERR-1:0] w_errf_I, w_errf_Q, w_errl_I, w_errl_Q;
   logic signed [2*NBT_ERR-1:0] w_sq_I, w_sq_Q;
   logic [MSE_W-1:0]          w_p;
   logic [ACC_W-1:0]          w_acc_next;

   logic signed [NBT_IN-1:0]  r_sym_I, r_sym_Q;
   logic signed [NBT_ERR-1:0] r_err_I, r_err_Q;
   logic                      r_valid;
   logic                      r_mse_valid;
   logic [MSE_W-1:0]          r_mse;
   logic [ACC_W-1:0]          r_acc;
   logic [LOG2_AVG-1:0]       r_cnt;
   logic                      r_mod;
   state_t                    r_state;
   logic [HIT_W-1:0]          r_hit;
   logic [MISS_W-1:0]         r_miss;

   eq_slicer_rail #(
      .NBT_IN(NBT_IN), .NBF_IN(NBF_IN), .NBT_ERR(NBT_ERR), .NBF_ERR(NBF_ERR)
   ) u_rail_i (
      .i_y(io_bus.i_data_I), .i_mod_sel(io_bus.i_mod_sel),
      .o_level(w_lvl_I), .o_err_full(w_errf_I), .o_err_lms(w_errl_I)
   );

   eq_slicer_rail #(
      .NBT_IN(NBT_IN), .NBF_IN(NBF_IN), .NBT_ERR(NBT_ERR), .NBF_ERR(NBF_ERR)
   ) u_rail_q (
      .i_y(io_bus.i_data_Q), .i_mod_sel(io_bus.i_mod_sel),
      .o_level(w_lvl_Q), .o_err_full(w_errf_Q), .o_err_lms(w_errl_Q)
   );

   assign w_strobe   = i_en_rx & io_bus.i_en_rate1;
   assign w_mod_chg  = (io_bus.i_mod_sel != r_mod);
   assign w_win_last = (r_cnt == '1);

   // Squares are non-negative, so the unsigned sum of both fits MSE_W bits.
   assign w_sq_I     = (2*NBT_ERR)'(w_errf_I) * (2*NBT_ERR)'(w_errf_I);
   assign w_sq_Q     = (2*NBT_ERR)'(w_errf_Q) * (2*NBT_ERR)'(w_errf_Q);
   assign w_p        = MSE_W'($unsigned(w_sq_I)) + MSE_W'($unsigned(w_sq_Q));
   assign w_acc_next = r_acc + ACC_W'(w_p);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (i_reset) begin
         r_sym_I     <= '0;
         r_sym_Q     <= '0;
         r_err_I     <= '0;
         r_err_Q     <= '0;
         r_valid     <= 1'b0;
         r_mse_valid <= 1'b0;
         r_mse       <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_mod       <= MOD_QPSK;
      end else begin
         // Pulses follow the qualified strobe each cycle, so they cannot
         // stay high while i_en_rx freezes the rest of the state.
         r_valid     <= w_strobe;
         r_mse_valid <= w_strobe & w_win_last & ~w_mod_chg;
         if (w_strobe) begin
            r_sym_I <= w_lvl_I;
            r_sym_Q <= w_lvl_Q;
            r_err_I <= w_errl_I;
            r_err_Q <= w_errl_Q;
            r_mod   <= io_bus.i_mod_sel;
            if (w_mod_chg) begin
               // Partial window is dropped; this symbol opens the new one.
               r_acc <= ACC_W'(w_p);
               r_cnt <= LOG2_AVG'(1);
            end else if (w_win_last) begin
               r_mse <= MSE_W'(w_acc_next >> LOG2_AVG);
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_next;
               r_cnt <= r_cnt + LOG2_AVG'(1);
            end
         end
      end
   end

   // Lock FSM. A modulation change (or the first strobe out of IDLE) forces
   // ACQ and overrides a window decision landing in the same cycle. The
   // window decision is taken on the one-cycle r_mse_valid pulse even if
   // i_en_rx has just dropped, so a completed window is never lost.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_hit   <= '0;
         r_miss  <= '0;
      end else if (w_strobe && (w_mod_chg || r_state == ST_IDLE)) begin
         r_state <= ST_ACQ;
         r_hit   <= '0;
         r_miss  <= '0;
      end else if (r_mse_valid) begin
         case (r_state)
            ST_ACQ: begin
               if (r_mse < MSE_W'(LOCK_THR)) begin
                  if (r_hit == HIT_W'(LOCK_CNT - 1)) begin
                     r_state <= ST_TRACK;
                     r_hit   <= '0;
                  end else begin
                     r_hit <= r_hit + HIT_W'(1);
                  end
               end else begin
                  r_hit <= '0;
               end
            end
            ST_TRACK: begin
               if (r_mse > MSE_W'(UNLOCK_THR)) begin
                  if (r_miss == MISS_W'(UNLOCK_CNT - 1)) begin
                     r_state <= ST_ACQ;
                     r_miss  <= '0;
                  end else begin
                     r_miss <= r_miss + MISS_W'(1);
                  end
               end else begin
                  r_miss <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign io_bus.o_sym_I = r_sym_I;
   assign io_bus.o_sym_Q = r_sym_Q;
   assign io_bus.o_err_I = r_err_I;
   assign io_bus.o_err_Q = r_err_Q;
   assign io_bus.o_valid = r_valid;
   assign o_mse          = r_mse;
   assign o_mse_valid    = r_mse_valid;
   assign o_state        = r_state;
   assign o_lock         = (r_state == ST_TRACK);
   assign o_step_sel     = (r_state == ST_TRACK);

endmodule
